// File: rtl/pong_game_controller.sv
// pong_game_controller: match sequencer for Pong. Owns the game FSM, the
// frame-counted serve / post-point delays, both scores and win detection.
module pong_game_controller #(
    parameter int WIN_SCORE          = 7,   // 1..15
    parameter int SERVE_DELAY_FRAMES = 60,  // 1..255
    parameter int POINT_PAUSE_FRAMES = 90   // 1..255
) (
    input  logic       clk,
    input  logic       reset,        // async, active-low
    input  logic       start,
    input  logic       pause,
    input  logic       frame_tick,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       game_on,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] winner,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SERVE     = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSED    = 3'd3,
        S_POINT     = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam logic [3:0] WIN_S   = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_D = 8'(SERVE_DELAY_FRAMES);
    localparam logic [7:0] POINT_D = 8'(POINT_PAUSE_FRAMES);

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    state_t     state, state_n;
    logic [3:0] score_l_n, score_r_n;
    logic [1:0] winner_n;
    logic       serve_dir_n;
    logic [7:0] cnt, cnt_n;
    logic       start_q;
    logic       start_rise;
    logic       delay_done;
    logic [3:0] score_l_inc, score_r_inc;

    assign start_rise = start & ~start_q;

    // A zero count can only appear through corruption; treat it as expired
    // so the FSM can never get stuck in a delay state.
    assign delay_done = (cnt <= 8'd1);

    // Saturating increments keep scores from ever passing WIN_SCORE.
    assign score_l_inc = (score_left  >= WIN_S) ? score_left  : score_left  + 4'd1;
    assign score_r_inc = (score_right >= WIN_S) ? score_right : score_right + 4'd1;

    // State, scores, winner, serve direction, counter and start edge register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            winner      <= WIN_NONE;
            serve_dir   <= 1'b1;
            cnt         <= 8'd0;
            start_q     <= 1'b0;
        end else begin
            state       <= state_n;
            score_left  <= score_l_n;
            score_right <= score_r_n;
            winner      <= winner_n;
            serve_dir   <= serve_dir_n;
            cnt         <= cnt_n;
            start_q     <= start;
        end
    end

    // Next-state and datapath updates; every field holds unless a case changes it.
    always_comb begin
        state_n     = state;
        score_l_n   = score_left;
        score_r_n   = score_right;
        winner_n    = winner;
        serve_dir_n = serve_dir;
        cnt_n       = cnt;

        case (state)
            S_IDLE, S_GAME_OVER: begin
                // serve_dir is left alone so the loser of the last point serves.
                if (start_rise) begin
                    score_l_n = 4'd0;
                    score_r_n = 4'd0;
                    winner_n  = WIN_NONE;
                    cnt_n     = SERVE_D;
                    state_n   = S_SERVE;
                end
            end

            S_SERVE: begin
                if (frame_tick) begin
                    if (delay_done) state_n = S_PLAY;
                    else            cnt_n   = cnt - 8'd1;
                end
            end

            S_POINT: begin
                if (frame_tick) begin
                    if (delay_done) begin
                        cnt_n   = SERVE_D;
                        state_n = S_SERVE;
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end

            S_PLAY: begin
                if (miss_left && miss_right) begin
                    // Simultaneous misses void the point.
                    cnt_n   = POINT_D;
                    state_n = S_POINT;
                end else if (miss_left) begin
                    score_r_n   = score_r_inc;
                    serve_dir_n = 1'b0;
                    if (score_r_inc == WIN_S) begin
                        winner_n = WIN_RIGHT;
                        state_n  = S_GAME_OVER;
                    end else begin
                        cnt_n   = POINT_D;
                        state_n = S_POINT;
                    end
                end else if (miss_right) begin
                    score_l_n   = score_l_inc;
                    serve_dir_n = 1'b1;
                    if (score_l_inc == WIN_S) begin
                        winner_n = WIN_LEFT;
                        state_n  = S_GAME_OVER;
                    end else begin
                        cnt_n   = POINT_D;
                        state_n = S_POINT;
                    end
                end else if (pause) begin
                    state_n = S_PAUSED;
                end
            end

            S_PAUSED: begin
                if (!pause) state_n = S_PLAY;
            end

            default: state_n = S_IDLE;
        endcase
    end

    // Output decode straight from the state register.
    always_comb begin
        game_on    = (state == S_PLAY);
        ball_reset = (state == S_IDLE) || (state == S_SERVE) ||
                     (state == S_POINT) || (state == S_GAME_OVER);
        state_out  = state;
    end

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller at default parameters
// (WIN_SCORE 7, serve 60 frames, point pause 90 frames).
module tb_pong_game_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       frame_tick = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       game_on, ball_reset, serve_dir;
    logic [3:0] score_left, score_right;
    logic [1:0] winner;
    logic [2:0] state_out;

    int errors = 0;
    int checks = 0;

    pong_game_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .frame_tick (frame_tick),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .game_on    (game_on),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .score_left (score_left),
        .score_right(score_right),
        .winner     (winner),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    // Inputs change on negedge; each helper returns on the negedge after the
    // posedge that sampled its stimulus, so outputs are settled on return.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        @(negedge clk) begin miss_left = l; miss_right = r; end
        @(negedge clk) begin miss_left = 1'b0; miss_right = 1'b0; end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({state_out, game_on, ball_reset, serve_dir} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_ctrl: got st=%0d on=%b br=%b sd=%b want st=0 on=0 br=1 sd=1",
                     state_out, game_on, ball_reset, serve_dir);
        end
        checks++;
        if ({score_left, score_right, winner} !== {4'd0, 4'd0, 2'b00}) begin
            errors++;
            $display("FAIL reset_score: got L=%0d R=%0d w=%b want 0 0 00",
                     score_left, score_right, winner);
        end
        @(negedge clk) reset = 1'b1;
        ticks(3);
        checks++;
        if (state_out !== 3'd0) begin
            errors++;
            $display("FAIL idle_no_start: got st=%0d want 0", state_out);
        end
    endtask

    task automatic test_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        checks++;
        if (state_out !== 3'd1 || game_on !== 1'b0 || ball_reset !== 1'b1) begin
            errors++;
            $display("FAIL start_serve: got st=%0d on=%b br=%b want st=1 on=0 br=1",
                     state_out, game_on, ball_reset);
        end
        repeat (9) @(negedge clk);
        start = 1'b0;
        ticks(59);
        checks++;
        if (state_out !== 3'd1 || game_on !== 1'b0) begin
            errors++;
            $display("FAIL serve_59: got st=%0d on=%b want st=1 on=0", state_out, game_on);
        end
        ticks(1);
        checks++;
        if (state_out !== 3'd2 || game_on !== 1'b1 || ball_reset !== 1'b0) begin
            errors++;
            $display("FAIL serve_60: got st=%0d on=%b br=%b want st=2 on=1 br=0",
                     state_out, game_on, ball_reset);
        end
        pulse_start();
        checks++;
        if (state_out !== 3'd2 || score_left !== 4'd0 || score_right !== 4'd0) begin
            errors++;
            $display("FAIL start_in_play: got st=%0d L=%0d R=%0d want st=2 L=0 R=0",
                     state_out, score_left, score_right);
        end
    endtask

    task automatic test_miss_left();
        pulse_miss(1'b1, 1'b0);
        checks++;
        if ({score_left, score_right, serve_dir, state_out, game_on} !==
            {4'd0, 4'd1, 1'b0, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL miss_left: got L=%0d R=%0d sd=%b st=%0d on=%b want 0 1 0 4 0",
                     score_left, score_right, serve_dir, state_out, game_on);
        end
        ticks(89);
        checks++;
        if (state_out !== 3'd4) begin
            errors++;
            $display("FAIL point_89: got st=%0d want 4", state_out);
        end
        ticks(1);
        checks++;
        if (state_out !== 3'd1) begin
            errors++;
            $display("FAIL point_90: got st=%0d want 1", state_out);
        end
        ticks(60);
        checks++;
        if (state_out !== 3'd2 || game_on !== 1'b1) begin
            errors++;
            $display("FAIL reserve_60: got st=%0d on=%b want st=2 on=1", state_out, game_on);
        end
    endtask

    task automatic test_void_point();
        pulse_miss(1'b1, 1'b1);
        checks++;
        if ({score_left, score_right, serve_dir, state_out} !== {4'd0, 4'd1, 1'b0, 3'd4}) begin
            errors++;
            $display("FAIL void_point: got L=%0d R=%0d sd=%b st=%0d want 0 1 0 4",
                     score_left, score_right, serve_dir, state_out);
        end
        ticks(150);
    endtask

    task automatic test_pause_vs_miss();
        @(negedge clk) begin pause = 1'b1; miss_right = 1'b1; end
        @(negedge clk) begin pause = 1'b0; miss_right = 1'b0; end
        checks++;
        if ({score_left, score_right, serve_dir, state_out} !== {4'd1, 4'd1, 1'b1, 3'd4}) begin
            errors++;
            $display("FAIL miss_beats_pause: got L=%0d R=%0d sd=%b st=%0d want 1 1 1 4",
                     score_left, score_right, serve_dir, state_out);
        end
        ticks(150);
        checks++;
        if (state_out !== 3'd2) begin
            errors++;
            $display("FAIL back_to_play: got st=%0d want 2", state_out);
        end
    endtask

    task automatic test_paused();
        @(negedge clk) pause = 1'b1;
        @(negedge clk);
        checks++;
        if (state_out !== 3'd3 || game_on !== 1'b0 || ball_reset !== 1'b0) begin
            errors++;
            $display("FAIL paused: got st=%0d on=%b br=%b want st=3 on=0 br=0",
                     state_out, game_on, ball_reset);
        end
        pulse_miss(1'b1, 1'b0);
        pulse_start();
        ticks(2);
        checks++;
        if ({state_out, score_left, score_right} !== {3'd3, 4'd1, 4'd1}) begin
            errors++;
            $display("FAIL paused_ignore: got st=%0d L=%0d R=%0d want 3 1 1",
                     state_out, score_left, score_right);
        end
        @(negedge clk) pause = 1'b0;
        @(negedge clk);
        checks++;
        if (state_out !== 3'd2) begin
            errors++;
            $display("FAIL unpause: got st=%0d want 2", state_out);
        end
    endtask

    task automatic test_win();
        for (int i = 0; i < 5; i++) begin
            pulse_miss(1'b0, 1'b1);
            ticks(150);
        end
        checks++;
        if ({score_left, state_out} !== {4'd6, 3'd2}) begin
            errors++;
            $display("FAIL pre_win: got L=%0d st=%0d want 6 2", score_left, state_out);
        end
        pulse_miss(1'b0, 1'b1);
        checks++;
        if ({score_left, score_right, winner, state_out} !== {4'd7, 4'd1, 2'b01, 3'd5}) begin
            errors++;
            $display("FAIL win_left: got L=%0d R=%0d w=%b st=%0d want 7 1 01 5",
                     score_left, score_right, winner, state_out);
        end
        pulse_miss(1'b1, 1'b0);
        pulse_miss(1'b0, 1'b1);
        ticks(100);
        checks++;
        if ({score_left, score_right, winner, state_out, ball_reset} !==
            {4'd7, 4'd1, 2'b01, 3'd5, 1'b1}) begin
            errors++;
            $display("FAIL game_over_hold: got L=%0d R=%0d w=%b st=%0d br=%b want 7 1 01 5 1",
                     score_left, score_right, winner, state_out, ball_reset);
        end
        pulse_start();
        checks++;
        if ({score_left, score_right, winner, state_out, serve_dir} !==
            {4'd0, 4'd0, 2'b00, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL restart: got L=%0d R=%0d w=%b st=%0d sd=%b want 0 0 00 1 1",
                     score_left, score_right, winner, state_out, serve_dir);
        end
        ticks(60);
    endtask

    task automatic test_reset_mid_point();
        pulse_miss(1'b1, 1'b0);
        ticks(30);
        checks++;
        if ({state_out, score_right} !== {3'd4, 4'd1}) begin
            errors++;
            $display("FAIL mid_point: got st=%0d R=%0d want 4 1", state_out, score_right);
        end
        @(posedge clk) #2 reset = 1'b0;
        #1;
        checks++;
        if ({state_out, score_left, score_right, ball_reset, game_on, serve_dir} !==
            {3'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got st=%0d L=%0d R=%0d br=%b on=%b sd=%b want 0 0 0 1 0 1",
                     state_out, score_left, score_right, ball_reset, game_on, serve_dir);
        end
        @(negedge clk) reset = 1'b1;
        ticks(70);
        checks++;
        if (state_out !== 3'd0 || game_on !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got st=%0d on=%b want 0 0", state_out, game_on);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_miss_left();
        test_void_point();
        test_pause_vs_miss();
        test_paused();
        test_win();
        // After the win test the game is in PLAY with 0-0.
        test_reset_mid_point();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_game_controller.md
# pong_game_controller

Top-level match sequencer for the Pong design: owns the game state machine, serve and inter-point delays, scorekeeping and win detection. It drives `game_on` to both paddle trackers and `ball_reset` / `serve_dir` to the ball mover, and it consumes miss events from the ball/collision logic. Frame-based delays are timed from the VGA frame tick, so every pause is independent of the clock frequency.

## Interface
Parameters:
- WIN_SCORE, 7, points needed to win (1..15)
- SERVE_DELAY_FRAMES, 60, frames the ball is held at centre before each serve (1..255)
- POINT_PAUSE_FRAMES, 90, frames of pause after a point is scored (1..255)

Ports:
- clk  in  1  system clock, the only clock; all logic is on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- start  in  1  start button, already synchronised; rising edge detected internally
- pause  in  1  level; pauses play while high
- frame_tick  in  1  one-cycle pulse per video frame
- miss_left  in  1  one-cycle pulse: ball passed the left paddle (point to the right player)
- miss_right  in  1  one-cycle pulse: ball passed the right paddle (point to the left player)
- game_on  out  1  paddles and ball may move; high only in PLAY
- ball_reset  out  1  holds the ball at screen centre; high in IDLE, SERVE, POINT and GAME_OVER
- serve_dir  out  1  0 = serve toward the left player, 1 = serve toward the right player
- score_left  out  4  left player score
- score_right  out  4  right player score
- winner  out  2  00 = none, 01 = left, 10 = right
- state_out  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, GAME_OVER=5

## Operation
- Reset values: state IDLE, scores 0, winner 00, serve_dir 1, frame counter 0, start edge register 0. As a result, game_on=0, ball_reset=1 and state_out=0.
- start_rise = start & ~start_q, where start_q is start registered by one cycle. Holding start high produces only one event.
- IDLE: on start_rise, clear both scores and winner, load the counter with SERVE_DELAY_FRAMES, and go to SERVE.
- SERVE and POINT: on each frame_tick, if the counter is 1 the delay expires, otherwise the counter decrements. A frame_tick in the same cycle as state entry is not counted.
  - On SERVE expiry, go to PLAY.
  - On POINT expiry, load SERVE_DELAY_FRAMES and go to SERVE.
- PLAY: events are checked in priority order, highest first.
  - miss_left & miss_right together: void point. Scores and serve_dir are unchanged; load POINT_PAUSE_FRAMES and go to POINT.
  - miss_left alone: score_right+1 and serve_dir<=0.
  - miss_right alone: score_left+1 and serve_dir<=1.
  - After a scoring miss, if the new score equals WIN_SCORE: set winner and go to GAME_OVER. Otherwise load POINT_PAUSE_FRAMES and go to POINT.
  - pause high with no miss: go to PAUSED. A miss always has priority over pause.
- PAUSED: go to PLAY when pause is low. Misses and start are ignored.
- GAME_OVER: scores and winner are held. start_rise behaves exactly as in IDLE, with serve_dir kept so the loser of the last point receives the serve.
- Misses are ignored in every state except PLAY. start is ignored in SERVE, PLAY, PAUSED and POINT.
- Scores never exceed WIN_SCORE and never wrap.

## Timing
- The state register, scores, winner, serve_dir and counter all update on the same posedge that samples the triggering input.
- game_on, ball_reset and state_out are decoded combinationally from the state register, so they change in the cycle after the triggering input is sampled.
- Latency from start pulse to game_on: start high at cycle N, then SERVE from N+1, then PLAY after the SERVE_DELAY_FRAMES-th frame_tick following N+1.
- Latency from miss to effect: the miss is sampled at edge N; the score, the state (POINT/GAME_OVER) and game_on=0 are visible after edge N.
- Reset asserted mid-operation forces all reset values asynchronously. The first start_rise after reset release is required before anything moves.

## Test plan
- Reset, then raise start and hold it 10 cycles; apply 60 frame_ticks → state_out 0→1, game_on rises only after the 60th tick, and exactly one start event occurs (a second raise while in PLAY has no effect).
- In PLAY, pulse miss_left → score_right=1, serve_dir=0, state POINT, game_on=0; after 90 ticks state SERVE, and after 60 more ticks state PLAY.
- Pulse miss_left and miss_right in the same cycle → both scores unchanged, serve_dir unchanged, state POINT.
- Set score_left to 6 and pulse miss_right → score_left=7, winner=01, state GAME_OVER; further misses are ignored; start_rise clears scores to 0, clears winner to 00, and enters SERVE with serve_dir=1.
- In PLAY, raise pause together with miss_right → point is scored and state POINT (miss wins). Later, with pause high in PLAY → PAUSED; a miss pulse there changes nothing; dropping pause returns to PLAY.
- Assert reset in the middle of the POINT countdown → immediately state IDLE, scores 0, ball_reset=1, game_on=0.
